// File: rtl/wb_port_arbiter_if.sv
// Write-port arbitration bus: pipeline write-back, long-latency result handshake,
// register-file write port and hazard-unit feedback (stall, pending destinations).
interface wb_port_arbiter_if;
    logic        pipe_RegWrite_i;
    logic [4:0]  pipe_RDaddr_i;
    logic [31:0] pipe_RDdata_i;

    logic        lu_valid_i;
    logic        lu_ready_o;
    logic [4:0]  lu_RDaddr_i;
    logic [31:0] lu_data_i;

    logic        RegWrite_o;
    logic [4:0]  RDaddr_o;
    logic [31:0] RDdata_o;

    logic        stall_o;
    logic [31:0] pending_mask_o;

    // Arbiter side.
    modport slave (
        input  pipe_RegWrite_i, pipe_RDaddr_i, pipe_RDdata_i,
        input  lu_valid_i, lu_RDaddr_i, lu_data_i,
        output lu_ready_o,
        output RegWrite_o, RDaddr_o, RDdata_o,
        output stall_o, pending_mask_o
    );

    // Pipeline / execution-unit / hazard-unit side.
    modport master (
        output pipe_RegWrite_i, pipe_RDaddr_i, pipe_RDdata_i,
        output lu_valid_i, lu_RDaddr_i, lu_data_i,
        input  lu_ready_o,
        input  RegWrite_o, RDaddr_o, RDdata_o,
        input  stall_o, pending_mask_o
    );
endinterface

// File: rtl/wb_port_arbiter.sv
// Shares the register-file write port: pipeline write-back passes through combinationally
// and always wins; long-latency results queue in a FIFO (ready = !full) and drain in free slots.
module wb_port_arbiter #(
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned MAX_WAIT = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    wb_port_arbiter_if.slave bus
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned AW = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [AW-1:0] AGE_MAX  = AW'(MAX_WAIT);

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } entry_t;

    entry_t        mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] age_q, age_d;
    logic          active_q;

    logic          empty;
    logic          full;
    logic          slot_busy;
    logic          lu_hs;
    logic          push;
    logic          pop;
    logic [31:0]   mask;

    assign empty     = (cnt_q == '0);
    assign full      = (cnt_q == FULL_CNT);
    assign slot_busy = bus.pipe_RegWrite_i && (bus.pipe_RDaddr_i != 5'd0);

    // active_q holds the port quiet from reset until the first edge after release.
    assign bus.lu_ready_o = active_q && !full;
    assign lu_hs          = bus.lu_valid_i && bus.lu_ready_o;
    assign push           = lu_hs && (bus.lu_RDaddr_i != 5'd0);
    assign pop            = active_q && !slot_busy && !empty;

    always_comb begin
        bus.RegWrite_o = 1'b0;
        bus.RDaddr_o   = 5'd0;
        bus.RDdata_o   = 32'd0;
        if (active_q) begin
            if (slot_busy) begin
                bus.RegWrite_o = 1'b1;
                bus.RDaddr_o   = bus.pipe_RDaddr_i;
                bus.RDdata_o   = bus.pipe_RDdata_i;
            end else if (!empty) begin
                bus.RegWrite_o = 1'b1;
                bus.RDaddr_o   = mem_q[rd_ptr_q].rd;
                bus.RDdata_o   = mem_q[rd_ptr_q].data;
            end
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Age counts only cycles where a queued head is passed over by the pipeline.
    always_comb begin
        age_d = age_q;
        if (empty || pop) begin
            age_d = '0;
        end else if (age_q != AGE_MAX) begin
            age_d = age_q + AW'(1);
        end
    end

    assign bus.stall_o = (age_q == AGE_MAX) || (full && bus.lu_valid_i);

    // An entry is live when its distance from the read pointer is below the count.
    always_comb begin
        mask = 32'd0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (CW'(PW'(PW'(i) - rd_ptr_q)) < cnt_q) begin
                mask[mem_q[i].rd] = 1'b1;
            end
        end
        mask[0] = 1'b0;
    end

    assign bus.pending_mask_o = mask;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            age_q    <= '0;
            active_q <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            age_q    <= age_d;
            active_q <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= '{rd: bus.lu_RDaddr_i, data: bus.lu_data_i};
        end
    end
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: combinational vector table plus directed multi-cycle sequences;
// every register-file write is matched against an in-order queue of expected writes.
module tb_wb_port_arbiter;
    logic clk_i = 1'b0;
    logic rst_i = 1'b1;

    always #5 clk_i = ~clk_i;

    wb_port_arbiter_if bus ();

    wb_port_arbiter #(.DEPTH(4), .MAX_WAIT(8)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    typedef struct packed {
        logic [4:0]  a;
        logic [31:0] d;
    } wr_t;

    typedef struct {
        logic        pw;
        logic [4:0]  pa;
        logic [31:0] pd;
        logic        we;
        logic [4:0]  a;
        logic [31:0] d;
    } vec_t;

    wr_t  sb_q [$];
    wr_t  mon_e;
    vec_t vt [6];
    int   n_chk = 0;
    int   n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%h, want 0x%h", nm, act, exp);
        end
    endtask

    task automatic cyc(input logic pw, input logic [4:0] pa, input logic [31:0] pd,
                       input logic lv, input logic [4:0] la, input logic [31:0] ld);
        @(negedge clk_i);
        bus.pipe_RegWrite_i = pw;
        bus.pipe_RDaddr_i   = pa;
        bus.pipe_RDdata_i   = pd;
        bus.lu_valid_i      = lv;
        bus.lu_RDaddr_i     = la;
        bus.lu_data_i       = ld;
        #1;
    endtask

    task automatic idle();
        cyc(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    task automatic expect_wr(input logic [4:0] a, input logic [31:0] d);
        sb_q.push_back({a, d});
    endtask

    // Scoreboard: every write seen on the port must be the next expected one.
    always begin
        @(negedge clk_i);
        #2;
        if (bus.RegWrite_o === 1'b1) begin
            n_chk++;
            if (sb_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_write: got addr=%0d data=0x%h, want no write",
                         bus.RDaddr_o, bus.RDdata_o);
            end else begin
                mon_e = sb_q.pop_front();
                if (bus.RDaddr_o !== mon_e.a || bus.RDdata_o !== mon_e.d) begin
                    n_err++;
                    $display("FAIL sb_write: got addr=%0d data=0x%h, want addr=%0d data=0x%h",
                             bus.RDaddr_o, bus.RDdata_o, mon_e.a, mon_e.d);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, want finish");
        $fatal(1);
    end

    task automatic fill_drain(input logic [4:0] base);
        logic [31:0] dv;
        for (int i = 0; i < 4; i++) begin
            dv = 32'hC0DE_0000 | (32'(base) << 8) | 32'(i);
            cyc(1'b1, 5'd3, 32'h3300_0000 + 32'(i), 1'b1, base + 5'(i), dv);
            expect_wr(5'd3, 32'h3300_0000 + 32'(i));
            chk("fill_ready", 32'(bus.lu_ready_o), 32'd1);
        end
        cyc(1'b1, 5'd3, 32'h3300_0004, 1'b1, base + 5'd4, 32'hBAD0_BAD0);
        expect_wr(5'd3, 32'h3300_0004);
        chk("full_ready", 32'(bus.lu_ready_o), 32'd0);
        chk("full_stall", 32'(bus.stall_o), 32'd1);
        cyc(1'b1, 5'd3, 32'h3300_0005, 1'b0, 5'd0, 32'd0);
        expect_wr(5'd3, 32'h3300_0005);
        chk("full_novalid_stall", 32'(bus.stall_o), 32'd0);
        chk("full_mask", bus.pending_mask_o, 32'hF << base);
        for (int i = 0; i < 4; i++) begin
            idle();
            dv = 32'hC0DE_0000 | (32'(base) << 8) | 32'(i);
            expect_wr(base + 5'(i), dv);
            chk("drain_ready", 32'(bus.lu_ready_o), (i > 0) ? 32'd1 : 32'd0);
        end
        idle();
        chk("drain_mask_clear", bus.pending_mask_o, 32'd0);
    endtask

    initial begin
        vt[0] = '{pw: 1'b0, pa: 5'd3,  pd: 32'h0000_AAAA, we: 1'b0, a: 5'd0,  d: 32'd0};
        vt[1] = '{pw: 1'b1, pa: 5'd3,  pd: 32'h0000_AAAA, we: 1'b1, a: 5'd3,  d: 32'h0000_AAAA};
        vt[2] = '{pw: 1'b1, pa: 5'd0,  pd: 32'h0000_DEAD, we: 1'b0, a: 5'd0,  d: 32'd0};
        vt[3] = '{pw: 1'b1, pa: 5'd31, pd: 32'hFFFF_FFFF, we: 1'b1, a: 5'd31, d: 32'hFFFF_FFFF};
        vt[4] = '{pw: 1'b0, pa: 5'd31, pd: 32'h0000_1234, we: 1'b0, a: 5'd0,  d: 32'd0};
        vt[5] = '{pw: 1'b1, pa: 5'd1,  pd: 32'h8000_0001, we: 1'b1, a: 5'd1,  d: 32'h8000_0001};

        bus.pipe_RegWrite_i = 1'b1;
        bus.pipe_RDaddr_i   = 5'd3;
        bus.pipe_RDdata_i   = 32'h55;
        bus.lu_valid_i      = 1'b0;
        bus.lu_RDaddr_i     = 5'd0;
        bus.lu_data_i       = 32'd0;
        #1 rst_i = 1'b0;
        #1;
        chk("rst_regwrite", 32'(bus.RegWrite_o), 32'd0);
        chk("rst_addr", 32'(bus.RDaddr_o), 32'd0);
        chk("rst_data", bus.RDdata_o, 32'd0);
        chk("rst_ready", 32'(bus.lu_ready_o), 32'd0);
        chk("rst_stall", 32'(bus.stall_o), 32'd0);
        chk("rst_mask", bus.pending_mask_o, 32'd0);

        @(negedge clk_i);
        bus.pipe_RegWrite_i = 1'b0;
        rst_i = 1'b1;
        idle();
        chk("post_rst_ready", 32'(bus.lu_ready_o), 32'd1);

        // Combinational passthrough with an empty FIFO.
        for (int i = 0; i < 6; i++) begin
            cyc(vt[i].pw, vt[i].pa, vt[i].pd, 1'b0, 5'd0, 32'd0);
            chk("tbl_we", 32'(bus.RegWrite_o), 32'(vt[i].we));
            chk("tbl_addr", 32'(bus.RDaddr_o), 32'(vt[i].a));
            chk("tbl_data", bus.RDdata_o, vt[i].d);
            if (vt[i].we) expect_wr(vt[i].a, vt[i].d);
        end

        // Single push into an idle pipeline: written the next cycle, mask high for one cycle.
        cyc(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'h1234);
        chk("t1_mask_before", bus.pending_mask_o, 32'd0);
        idle();
        expect_wr(5'd5, 32'h1234);
        chk("t1_mask_set", bus.pending_mask_o, 32'h20);
        idle();
        chk("t1_mask_clear", bus.pending_mask_o, 32'd0);

        // Starvation: pipeline busy every cycle, stall after 8 ungranted cycles.
        cyc(1'b1, 5'd3, 32'h3000_0000, 1'b1, 5'd7, 32'h77);
        expect_wr(5'd3, 32'h3000_0000);
        for (int k = 1; k <= 10; k++) begin
            cyc(1'b1, 5'd3, 32'h3000_0000 + 32'(k), 1'b0, 5'd0, 32'd0);
            expect_wr(5'd3, 32'h3000_0000 + 32'(k));
            chk("t2_stall", 32'(bus.stall_o), (k >= 9) ? 32'd1 : 32'd0);
        end
        idle();
        expect_wr(5'd7, 32'h77);
        chk("t2_bubble_we", 32'(bus.RegWrite_o), 32'd1);
        chk("t2_bubble_stall", 32'(bus.stall_o), 32'd1);
        idle();
        chk("t2_stall_drop", 32'(bus.stall_o), 32'd0);

        // Two full fills with pointer wrap-around.
        fill_drain(5'd10);
        fill_drain(5'd20);

        // Destination 0: accepted, discarded; pipeline write to r0 is suppressed.
        cyc(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hFFFF_FFFF);
        chk("t4_ready", 32'(bus.lu_ready_o), 32'd1);
        cyc(1'b1, 5'd0, 32'h0000_DEAD, 1'b0, 5'd0, 32'd0);
        chk("t4_pipe_r0_we", 32'(bus.RegWrite_o), 32'd0);
        chk("t4_mask", bus.pending_mask_o, 32'd0);
        idle();
        chk("t4_no_write", 32'(bus.RegWrite_o), 32'd0);

        // Duplicate destination keeps the mask bit until the last pop.
        cyc(1'b1, 5'd3, 32'h4400_0000, 1'b1, 5'd9, 32'h9999_000A);
        expect_wr(5'd3, 32'h4400_0000);
        cyc(1'b1, 5'd3, 32'h4400_0001, 1'b1, 5'd9, 32'h9999_000B);
        expect_wr(5'd3, 32'h4400_0001);
        chk("t5_mask_c1", bus.pending_mask_o, 32'h200);
        idle();
        expect_wr(5'd9, 32'h9999_000A);
        chk("t5_mask_c2", bus.pending_mask_o, 32'h200);
        idle();
        expect_wr(5'd9, 32'h9999_000B);
        chk("t5_mask_c3", bus.pending_mask_o, 32'h200);
        idle();
        chk("t5_mask_c4", bus.pending_mask_o, 32'd0);

        // Reset mid-drain with three entries still queued.
        cyc(1'b1, 5'd3, 32'h5500_0000, 1'b1, 5'd1, 32'h0101_0101);
        expect_wr(5'd3, 32'h5500_0000);
        cyc(1'b1, 5'd3, 32'h5500_0001, 1'b1, 5'd2, 32'h0202_0202);
        expect_wr(5'd3, 32'h5500_0001);
        cyc(1'b1, 5'd3, 32'h5500_0002, 1'b1, 5'd4, 32'h0404_0404);
        expect_wr(5'd3, 32'h5500_0002);
        cyc(1'b1, 5'd3, 32'h5500_0003, 1'b1, 5'd6, 32'h0606_0606);
        expect_wr(5'd3, 32'h5500_0003);
        idle();
        expect_wr(5'd1, 32'h0101_0101);
        chk("t6_mask_pre", bus.pending_mask_o, 32'h56);
        @(negedge clk_i);
        bus.pipe_RegWrite_i = 1'b1;
        bus.pipe_RDaddr_i   = 5'd3;
        bus.pipe_RDdata_i   = 32'h6600_0000;
        rst_i = 1'b0;
        #1;
        chk("t6_rst_we", 32'(bus.RegWrite_o), 32'd0);
        chk("t6_rst_addr", 32'(bus.RDaddr_o), 32'd0);
        chk("t6_rst_data", bus.RDdata_o, 32'd0);
        chk("t6_rst_ready", 32'(bus.lu_ready_o), 32'd0);
        chk("t6_rst_stall", 32'(bus.stall_o), 32'd0);
        chk("t6_rst_mask", bus.pending_mask_o, 32'd0);
        @(negedge clk_i);
        bus.pipe_RegWrite_i = 1'b0;
        rst_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            idle();
            chk("t6_post_we", 32'(bus.RegWrite_o), 32'd0);
            chk("t6_post_mask", bus.pending_mask_o, 32'd0);
        end
        chk("t6_post_ready", 32'(bus.lu_ready_o), 32'd1);

        idle();
        chk("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/wb_port_arbiter.md
# wb_port_arbiter

Shares the single register-file write port between the in-order pipeline write-back (output of the MEM/WB register, after the MemtoReg mux) and results returned by a long-latency execution unit (multiply/divide). Pipeline write-back always wins the port. Long-latency results queue in a small FIFO and drain in free write-back slots. An age counter forces pipeline bubbles when a queued result starves, and a pending-destination mask lets the hazard unit stall readers of not-yet-written registers.

## Interface
- DEPTH, 4, FIFO entries; power of two, at least 2
- MAX_WAIT, 8, cycles a non-empty FIFO head may go ungranted before a stall is requested; at least 1
- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous, active-low reset
- pipe_RegWrite_i  in  1  write-back valid from MEM/WB
- pipe_RDaddr_i  in  5  write-back destination register
- pipe_RDdata_i  in  32  write-back data (post MemtoReg mux)
- lu_valid_i  in  1  long-latency result valid
- lu_ready_o  out  1  arbiter can accept a result
- lu_RDaddr_i  in  5  long-latency destination register
- lu_data_i  in  32  long-latency result
- RegWrite_o  out  1  register-file write enable
- RDaddr_o  out  5  register-file write address
- RDdata_o  out  32  register-file write data
- stall_o  out  1  request that the hazard unit insert a write-back bubble
- pending_mask_o  out  32  bit r set when a queued result targets register r

## Operation
- FIFO: circular buffer of DEPTH entries {rd[4:0], data[31:0]}. Read and write pointers are log2(DEPTH) bits and wrap modulo DEPTH. A count register of log2(DEPTH)+1 bits distinguishes full from empty.
- Push: lu_valid_i && lu_ready_o at the rising edge. lu_ready_o = !full. No push when full, even if a pop happens in the same cycle.
- A handshaken result with lu_RDaddr_i == 0 is accepted and discarded: no push, no mask bit.
- Pipeline slot is busy when pipe_RegWrite_i && pipe_RDaddr_i != 0.
- Grant, combinational, each cycle:
  - Slot busy: RegWrite_o=1, RDaddr_o/RDdata_o = pipe inputs. No pop.
  - Slot free and FIFO not empty: drive the head entry with RegWrite_o=1 and pop at the edge.
  - Otherwise: RegWrite_o=0, RDaddr_o=0, RDdata_o=0.
- A pipeline write to register 0 never reaches the port (RegWrite_o=0 unless the FIFO drains in that slot).
- Age counter age_q:
  - Width log2(MAX_WAIT+1), saturates at MAX_WAIT.
  - Cleared when the FIFO is empty or a pop occurs.
  - Otherwise increments each cycle the FIFO is non-empty and the head is not granted.
- stall_o = (age_q == MAX_WAIT) || (full && lu_valid_i). The hazard unit answers with bubbles (pipe_RegWrite_i=0). stall_o drops the cycle after the head pops and age_q clears, unless full && lu_valid_i still holds.
- pending_mask_o: combinational OR of one-hot(rd) over all valid entries. Bit 0 is always 0. Duplicate rds in the FIFO keep the bit set until the last matching entry pops.
- Ordering: the FIFO drains strictly in arrival order. The arbiter performs no rd conflict checking between pipeline and queued writes; the hazard unit uses pending_mask_o to prevent WAW/RAW conflicts.

## Timing
- Reset (rst_i=0, asynchronous) clears:
  - FIFO count, pointers, age_q.
  - Outputs: RegWrite_o=0, RDaddr_o=0, RDdata_o=0, lu_ready_o=0, stall_o=0, pending_mask_o=0.
  - The FIFO data array is not cleared.
- First edge after release: lu_ready_o=1.
- Reset mid-operation discards all queued results.
- Pipeline write: zero latency, combinational passthrough; the register file writes on the same edge.
- Long-latency result, minimum latency: pushed at edge N, eligible for the port in cycle N+1, written at edge N+1 if that slot is free.
- pending_mask_o: bit rises the cycle after the push edge and falls the cycle after the pop edge.
- Push and pop in the same cycle (not full): count unchanged, both pointers advance.
- Starvation bound: a head entry is written at most MAX_WAIT + hazard-unit bubble latency cycles after becoming head.

## Test plan
- Idle pipeline, lu pushes rd=5/0x1234: cycle N+1 RegWrite_o=1, RDaddr_o=5, RDdata_o=0x1234; pending_mask_o[5] high for exactly one cycle.
- Pipeline writes rd=3 every cycle while lu pushes rd=7: the pipeline wins each cycle. stall_o rises after MAX_WAIT (8) ungranted cycles. The first bubble writes rd=7 and stall_o drops the next cycle.
- Fill DEPTH=4 entries with a continuously busy pipeline: lu_ready_o=0 after the 4th push. A fifth lu_valid_i asserts stall_o. Entries drain in order with pointer wrap-around over two fills.
- Push rd=0 with data 0xFFFF_FFFF: accepted, never written, mask stays 0. A pipeline write to rd=0 gives RegWrite_o=0.
- Two pushes to rd=9 then drain: pending_mask_o[9] stays high until the second pop.
- Assert rst_i low mid-drain with 3 entries queued: all outputs are 0 immediately. After release, no stale write appears.
